mc_control_unit: RTL



---
 rtl/mc_ctrl_pkg.sv | 71 +++++++
 rtl/mc_op_decode.sv | 45 ++++
 rtl/mc_control_unit.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS-lite main control unit:
// state encoding, opcodes, datapath select encodings, branch/jump classes
// and the decoded instruction-class record.
package mc_ctrl_pkg;

  // State encoding (4-bit, also exported on the debug 'state' port)
  typedef logic [3:0] state_t;
  localparam state_t S_FETCH  = 4'd0;
  localparam state_t S_DECODE = 4'd1;
  localparam state_t S_MEMADR = 4'd2;
  localparam state_t S_MEMRD  = 4'd3;
  localparam state_t S_MEMWB  = 4'd4;
  localparam state_t S_MEMWR  = 4'd5;
  localparam state_t S_EXEC_R = 4'd6;
  localparam state_t S_WB_R   = 4'd7;
  localparam state_t S_EXEC_I = 4'd8;
  localparam state_t S_WB_I   = 4'd9;
  localparam state_t S_BRANCH = 4'd10;
  localparam state_t S_JUMP   = 4'd11;
  localparam state_t S_JSPAL  = 4'd12;
  localparam state_t S_TRAP   = 4'd13;

  // Opcodes (6-bit form)
  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BLTZ  = 6'b000001;
  localparam logic [5:0] OP_NORI  = 6'b001101;
  localparam logic [5:0] OP_BZ    = 6'b011000;
  localparam logic [5:0] OP_JSPAL = 6'b010011;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ALU operation select
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_NORI  = 2'b11;

  // ALU B-operand select
  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_SIMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Branch/jump class
  localparam logic [2:0] BJ_NONE  = 3'b000;
  localparam logic [2:0] BJ_BEQ   = 3'b110;
  localparam logic [2:0] BJ_BLTZ  = 3'b101;
  localparam logic [2:0] BJ_BZ    = 3'b001;
  localparam logic [2:0] BJ_JSPAL = 3'b011;
  localparam logic [2:0] BJ_J     = 3'b010;

  // One-hot instruction class produced by the opcode decoder
  typedef struct packed {
    logic is_r;
    logic is_lw;
    logic is_sw;
    logic is_nori;
    logic is_branch;
    logic is_j;
    logic is_jspal;
    logic is_illegal;
  } op_class_t;

endpackage

// File: rtl/mc_op_decode.sv
// Combinational opcode decoder: opcode -> instruction-class one-hots plus
// branch/jump class. Same decode as the single-cycle controller.
import mc_ctrl_pkg::*;

module mc_op_decode #(
  parameter int OPCODE_W = 6
) (
  input  logic [OPCODE_W-1:0] op,
  output op_class_t           cls,
  output logic [2:0]          bj
);

  // Opcode compare chain; anything unmatched is illegal
  always_comb begin
    cls = '0;
    bj  = BJ_NONE;
    if (op == OPCODE_W'(OP_R)) begin
      cls.is_r = 1'b1;
    end else if (op == OPCODE_W'(OP_LW)) begin
      cls.is_lw = 1'b1;
    end else if (op == OPCODE_W'(OP_SW)) begin
      cls.is_sw = 1'b1;
    end else if (op == OPCODE_W'(OP_NORI)) begin
      cls.is_nori = 1'b1;
    end else if (op == OPCODE_W'(OP_BEQ)) begin
      cls.is_branch = 1'b1;
      bj            = BJ_BEQ;
    end else if (op == OPCODE_W'(OP_BLTZ)) begin
      cls.is_branch = 1'b1;
      bj            = BJ_BLTZ;
    end else if (op == OPCODE_W'(OP_BZ)) begin
      cls.is_branch = 1'b1;
      bj            = BJ_BZ;
    end else if (op == OPCODE_W'(OP_J)) begin
      cls.is_j = 1'b1;
      bj       = BJ_J;
    end else if (op == OPCODE_W'(OP_JSPAL)) begin
      cls.is_jspal = 1'b1;
      bj           = BJ_JSPAL;
    end else begin
      cls.is_illegal = 1'b1;
    end
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle main control FSM for the MIPS-lite datapath. Moore strobes
// decoded from the state register, with mem_ready gating in FETCH/JSPAL.
// Optional feature macro: MC_CTRL_MEM_TIMEOUT_EN (memory wait timeout trap).
import mc_ctrl_pkg::*;

module mc_control_unit #(
  parameter int OPCODE_W    = 6,
  parameter int RET_CNT_W   = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [OPCODE_W-1:0]  opcode,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 pc_write_cond,
  output logic                 iord,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic                 mem_to_reg,
  output logic                 reg_dst,
  output logic                 reg_write,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic [1:0]           pc_source,
  output logic [2:0]           bj,
  output logic                 trap,
  output logic                 trap_cause,
  output logic [3:0]           state,
  output logic [RET_CNT_W-1:0] retired
);

  state_t              state_q, state_next;
  logic [OPCODE_W-1:0] op_q;
  logic [2:0]          bj_q;
  logic                trap_q;
  op_class_t           dec_cls;
  logic [2:0]          dec_bj;
  logic                wait_st;

  // Dispatch decodes the live opcode in DECODE so the next state is ready
  // on time; op_q/bj_q capture it for the rest of the instruction.
  mc_op_decode #(.OPCODE_W(OPCODE_W)) u_dec (
    .op  (opcode),
    .cls (dec_cls),
    .bj  (dec_bj)
  );

  assign wait_st = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                   (state_q == S_MEMWR) || (state_q == S_JSPAL);

`ifdef MC_CTRL_MEM_TIMEOUT_EN
  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
  logic [WC_W-1:0] wait_cnt;
  logic            timeout_hit;
  logic            cause_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (MEM_TIMEOUT != 0);
`endif

  // Next-state logic; a timeout overrides the normal wait only when mem_ready=0
  always_comb begin
    state_next = state_q;
`ifdef MC_CTRL_MEM_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    case (state_q)
      S_FETCH:  if (mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        if (dec_cls.is_lw || dec_cls.is_sw) state_next = S_MEMADR;
        else if (dec_cls.is_r)              state_next = S_EXEC_R;
        else if (dec_cls.is_nori)           state_next = S_EXEC_I;
        else if (dec_cls.is_branch)         state_next = S_BRANCH;
        else if (dec_cls.is_j)              state_next = S_JUMP;
        else if (dec_cls.is_jspal)          state_next = S_JSPAL;
        else                                state_next = S_TRAP;
      end
      S_MEMADR: state_next = (op_q == OPCODE_W'(OP_LW)) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_next = S_MEMWB;
      S_MEMWB:  state_next = S_FETCH;
      S_MEMWR:  if (mem_ready) state_next = S_FETCH;
      S_EXEC_R: state_next = S_WB_R;
      S_WB_R:   state_next = S_FETCH;
      S_EXEC_I: state_next = S_WB_I;
      S_WB_I:   state_next = S_FETCH;
      S_BRANCH: state_next = S_FETCH;
      S_JUMP:   state_next = S_FETCH;
      S_JSPAL:  if (mem_ready) state_next = S_FETCH;
      S_TRAP:   state_next = S_TRAP;
      default:  state_next = S_FETCH;
    endcase
`ifdef MC_CTRL_MEM_TIMEOUT_EN
    if (wait_st && !mem_ready && (wait_cnt == WC_W'(MEM_TIMEOUT))) begin
      state_next  = S_TRAP;
      timeout_hit = 1'b1;
    end
`endif
  end

  // State, latched opcode/class, sticky trap and retired-instruction counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      bj_q    <= BJ_NONE;
      trap_q  <= 1'b0;
      retired <= '0;
    end else begin
      state_q <= state_next;
      if (state_q == S_DECODE) begin
        op_q <= opcode;
        bj_q <= dec_bj;
      end
      if (state_next == S_TRAP) trap_q <= 1'b1;
      // A FETCH->FETCH self-loop is a stalled fetch, not a retirement
      if ((state_next == S_FETCH) && (state_q != S_FETCH) && (state_q != S_TRAP))
        retired <= retired + RET_CNT_W'(1);
    end
  end

`ifdef MC_CTRL_MEM_TIMEOUT_EN
  // Wait counter: cleared on any state change, counts mem_ready=0 cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
      cause_q  <= 1'b0;
    end else begin
      if (state_next != state_q)
        wait_cnt <= '0;
      else if (wait_st && !mem_ready && (wait_cnt != WC_W'(MEM_TIMEOUT)))
        wait_cnt <= wait_cnt + 1'b1;
      if (timeout_hit) cause_q <= 1'b1;
    end
  end
  assign trap_cause = cause_q;
`else
  assign trap_cause = 1'b0;
`endif

  assign trap  = trap_q;
  assign bj    = bj_q;
  assign state = state_q;

  // Per-state datapath strobes
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    alu_op        = ALUOP_ADD;
    pc_source     = PCSRC_ALU;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        alu_src_b = SRCB_FOUR;
      end
      S_DECODE: alu_src_b = SRCB_IMM_SH2;
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_SIMM;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      S_WB_R: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_SIMM;
        alu_op    = ALUOP_NORI;
      end
      S_WB_I: reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
      end
      S_JSPAL: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        pc_write  = mem_ready;
        pc_source = mem_ready ? PCSRC_JUMP : PCSRC_ALU;
      end
      default: ;
    endcase
  end

endmodule
